// File: rtl/aes_key_expand_gen.sv
// AES key-schedule engine for AES-128/192/256.
// Produces one 32-bit schedule word per cycle into a 60-word store. SubWord
// is done by an external S-box through the sboxw/new_sboxw pair, whose result
// is taken SBOX_LAT cycles after sboxw is presented. Round keys are read
// combinationally through rk_idx once ready is high.
//
// Debug state encoding on dbg_state: 0=IDLE 1=LOAD 2=GEN 3=SUBW 4=DONE.
//
// Handshake: init is a start request that is accepted only in IDLE or DONE;
// a request seen in any other state is dropped. ready stays high from the
// end of expansion until the next accepted init, and rk is valid only while
// ready is high.
module aes_key_expand_gen #(
    parameter int SBOX_LAT = 1,
    parameter int NW_MAX   = 60
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk,
    output logic [3:0]   nr,
    output logic         busy,
    output logic         ready,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_GEN  = 3'd2,
        S_SUBW = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(SBOX_LAT - 1);

    state_t       state;
    logic [1:0]   mode_q;      // 0=128, 1=192, 2=256 (key_len 3 folds to 0)
    logic [255:0] key_q;
    logic [5:0]   i_q;         // index of the word being produced
    logic [2:0]   pos_q;       // i % Nk, tracked incrementally
    logic [3:0]   rnd_q;       // i / Nk, selects Rcon
    logic [1:0]   lat_cnt;
    logic [31:0]  w_mem [NW_MAX];

    logic [5:0]   nk;
    logic [5:0]   nt;
    logic [5:0]   idx_prev;
    logic [5:0]   idx_back;
    logic [31:0]  w_prev;
    logic [31:0]  w_back;
    logic         need_sub;
    logic         sub_done;
    logic         wr_en;
    logic [31:0]  wr_data;
    logic [31:0]  rcon_word;
    logic         last_word;
    logic         pos_wrap;
    logic [2:0]   pos_next;
    logic [3:0]   rnd_next;
    state_t       state_after_word;
    logic         rk_sel;
    logic [5:0]   rk_base;

    assign dbg_state = state;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Per-mode word counts derived from the latched mode
    always_comb begin
        nk = 6'd4;
        nt = 6'd44;
        case (mode_q)
            2'd1: begin nk = 6'd6; nt = 6'd52; end
            2'd2: begin nk = 6'd8; nt = 6'd60; end
            default: begin nk = 6'd4; nt = 6'd44; end
        endcase
    end

    // Next-word datapath: operand fetch, SubWord decision and write data
    always_comb begin
        idx_prev  = i_q - 6'd1;
        idx_back  = i_q - nk;
        w_prev    = w_mem[idx_prev];
        w_back    = w_mem[idx_back];
        need_sub  = (pos_q == 3'd0) || ((mode_q == 2'd2) && (pos_q == 3'd4));
        sub_done  = (state == S_SUBW) && (lat_cnt == LAT_LAST);
        wr_en     = ((state == S_GEN) && !need_sub) || sub_done;
        rcon_word = (pos_q == 3'd0) ? {rcon(rnd_q), 24'h0} : 32'h0;
        wr_data   = (state == S_SUBW) ? (w_back ^ new_sboxw ^ rcon_word)
                                      : (w_back ^ w_prev);
        last_word = (i_q == nt - 6'd1);
        pos_wrap  = ({3'b000, pos_q} == nk - 6'd1);
        pos_next  = pos_wrap ? 3'd0 : pos_q + 3'd1;
        rnd_next  = pos_wrap ? rnd_q + 4'd1 : rnd_q;
        state_after_word = last_word ? S_DONE : S_GEN;
    end

    // Round-key read port, forced to zero unless the schedule is complete
    always_comb begin
        rk_sel  = ready && (rk_idx <= nr);
        rk_base = {(rk_sel ? rk_idx : 4'd0), 2'b00};
        rk      = 128'h0;
        if (rk_sel) begin
            rk = {w_mem[rk_base], w_mem[rk_base + 6'd1],
                  w_mem[rk_base + 6'd2], w_mem[rk_base + 6'd3]};
        end
    end

    // Word store: key words in LOAD, one schedule word per completed step
    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            for (int j = 0; j < 8; j++) begin
                if (6'(j) < nk) begin
                    w_mem[6'(j)] <= key_q[255 - 32*j -: 32];
                end
            end
        end else if (wr_en) begin
            w_mem[i_q] <= wr_data;
        end
    end

    // Control FSM with registered status and S-box outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            ready   <= 1'b0;
            busy    <= 1'b0;
            sboxw   <= 32'h0;
            nr      <= 4'd0;
            mode_q  <= 2'd0;
            key_q   <= 256'h0;
            i_q     <= 6'd0;
            pos_q   <= 3'd0;
            rnd_q   <= 4'd0;
            lat_cnt <= 2'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (init) begin
                        state  <= S_LOAD;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                        key_q  <= key;
                        mode_q <= (key_len == 2'd3) ? 2'd0 : key_len;
                        case (key_len)
                            2'd1:    nr <= 4'd12;
                            2'd2:    nr <= 4'd14;
                            default: nr <= 4'd10;
                        endcase
                    end
                end
                S_LOAD: begin
                    i_q   <= nk;
                    pos_q <= 3'd0;
                    rnd_q <= 4'd1;
                    state <= S_GEN;
                end
                S_GEN: begin
                    if (need_sub) begin
                        sboxw   <= (pos_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
                        lat_cnt <= 2'd0;
                        state   <= S_SUBW;
                    end else begin
                        i_q   <= i_q + 6'd1;
                        pos_q <= pos_next;
                        rnd_q <= rnd_next;
                        state <= state_after_word;
                        if (last_word) begin
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_SUBW: begin
                    if (lat_cnt == LAT_LAST) begin
                        sboxw <= 32'h0;
                        i_q   <= i_q + 6'd1;
                        pos_q <= pos_next;
                        rnd_q <= rnd_next;
                        state <= state_after_word;
                        if (last_word) begin
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes_key_expand_gen.md
Name: aes_key_expand_gen

Overview:
- Parametrised AES key-schedule engine supporting AES-128, AES-192 and AES-256, selected per run by a mode input.
- Generates one 32-bit word per cycle into an internal 60-word store.
- SubWord is performed by a shared external S-box through a fixed-latency sboxw/new_sboxw port pair.
- Round keys are read through an indexed read port, feeding the cipher datapath once ready is high.

Parameters:
SBOX_LAT, 1, cycles from sboxw driven to new_sboxw valid; legal range 1..4.
NW_MAX, 60, word-store depth (4*(14+1)); fixed, not user-reduced.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous active-low reset.
init  input  1  start pulse; sampled only in IDLE or DONE.
key_len  input  2  0=AES-128, 1=AES-192, 2=AES-256, 3=treated as AES-128; latched on accepted init.
key  input  256  cipher key, MSB-first; 128-bit uses [255:128], 192-bit uses [255:64].
sboxw  output  32  word presented to the external S-box.
new_sboxw  input  32  S-box result, valid SBOX_LAT cycles after sboxw.
rk_idx  input  4  round-key index, 0..nr.
rk  output  128  {w[4k],w[4k+1],w[4k+2],w[4k+3]} for k=rk_idx; combinational read.
nr  output  4  rounds for latched mode: 10/12/14; 0 in reset.
busy  output  1  high while expanding.
ready  output  1  high when the schedule is complete and valid.

Behaviour:
- Reset (async, reset_n low):
  - State goes to IDLE.
  - ready=0, busy=0, sboxw=0, nr=0, rk=0.
  - Word store is not cleared; rk is gated to 0 whenever ready=0.
- Per-mode constants: Nk=4/6/8, Nr=10/12/14, Nt=4*(Nr+1)=44/52/60.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36 in byte [31:24], indexed by i/Nk starting at 1.
- States:
  - IDLE -> LOAD on init.
  - LOAD: write w[0..Nk-1] from key in one cycle; i=Nk; busy=1.
  - GEN: compute word i.
    - If i%Nk==0: temp=RotWord(w[i-1]), go to SUBW.
    - Else if Nk==8 and i%8==4: temp=w[i-1], go to SUBW.
    - Otherwise w[i]=w[i-Nk]^w[i-1] this cycle, i++.
  - SUBW: drive sboxw=temp and hold it stable for the full wait. Sample new_sboxw on the SBOX_LAT-th rising edge after entry, then:
    - w[i]=w[i-Nk]^new_sboxw^(i%Nk==0 ? Rcon[i/Nk] : 0); i++; return to GEN.
  - When i reaches Nt: go to DONE; ready=1, busy=0.
  - DONE -> LOAD on init; ready drops to 0 in the cycle LOAD is entered.
- sboxw=0 in every state except SUBW.
- Latency from accepted init edge to ready high: 1 + (Nt-Nk) + nsub*SBOX_LAT cycles, where nsub=10/8/13.
  - SBOX_LAT=1: 51 / 55 / 66 cycles.
- init while busy is ignored; key and key_len changes while busy have no effect.
- rk_idx > nr gives rk=0. rk is always 0 while ready=0.
- Reset asserted mid-expansion aborts immediately. After reset release, the block waits for a new init.
- RotWord rotates left by one byte: {w[23:0],w[31:24]}.
- No partial or early round-key availability is guaranteed.

Test Plan:
1. Reset then AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, SBOX_LAT=1:
   - ready rises exactly 51 cycles after init and nr=10.
   - rk_idx=0 -> 2b7e151628aed2a6abf7158809cf4f3c.
   - rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
2. AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
   - ready after 55 cycles, nr=12.
   - rk_idx=12 -> e98ba06f448c773c8ecc720401002202.
   - rk_idx=13 -> 0.
3. AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
   - ready after 66 cycles, nr=14.
   - rk_idx=14 -> fe4890d1e6188d0b046df344706c631e.
   - Exactly 13 SUBW entries.
4. SBOX_LAT=3 with the bench S-box model delayed 3 cycles, vector 1:
   - ready after 71 cycles, same rk values.
   - sboxw held stable for 3 cycles in each SUBW.
5. init pulsed at cycle 20 of an AES-128 run -> ignored; results identical to vector 1. Second init in DONE with AES-256 key -> ready drops next cycle and rerun matches vector 3.
6. reset_n low at cycle 30 of the AES-192 run:
   - ready, busy, sboxw and rk go to 0 asynchronously.
   - After release with no init, state stays IDLE; a subsequent AES-128 run matches vector 1.
